pll_sequencer_csr: RTL and testbench
====================================

Name: pll_sequencer_csr

Overview:
- Parametrised successor to the single-PLL control/status register.
- Controls power for NUM_PLLS PLLs and sequences the image-buffer clock-select handshake: the buffer clock moves to SPI before any PLL drops, and returns only after every enabled PLL reports lock.
- Adds a lock timeout, a fault state, a dropped-command flag and registered status readback.
- Sits beside the chip-ID register on the SPI opcode/operand bus; drives the DCS select and the PLL powerdown pins.

Parameters:
- NUM_PLLS, 2, number of controlled PLLs; legal range 1..4.
- CTRL_ADDRESS, 'hE0, opcode for the control register (write and read).
- STATUS_ADDRESS, 'hE1, opcode for the read-only status register.
- SETTLE_CYCLES, 16, clock_in cycles waited around each clock-select change; must be at least 1.
- LOCK_TIMEOUT, 1024, clock_in cycles allowed for lock after power-up; must be at least 2.

Ports:
- clock_in  input  1  free-running clock (oscillator domain); sole clock.
- reset_in  input  1  synchronous, active-high reset.
- opcode_in  input  8  SPI opcode, already synchronous to clock_in.
- operand_in  input  8  SPI write data.
- operand_valid_in  input  1  one-cycle write strobe for operand_in.
- response_out  output  8  registered read data.
- pll_locked_in  input  NUM_PLLS  raw lock status, one bit per PLL.
- pllpowerdown_n_out  output  NUM_PLLS  1 = PLL powered.
- buffer_clock_sel_out  output  1  1 = image buffer clocked from SPI clock.
- busy_out  output  1  high whenever the FSM is not in IDLE or FAULT.

Behaviour:
- Control register: {read_req[7], reserved[6:NUM_PLLS], target[NUM_PLLS-1:0]}.
- Reset values:
  - target = all ones, read_req = 0.
  - pllpowerdown_n_out = all ones, buffer_clock_sel_out = 1.
  - response_out = 0, drop = 0, fault = 0, counter = 0.
  - State = WAIT_LOCK, i.e. power-up sequencing begins straight out of reset.
- Command acceptance:
  - A write is opcode_in == CTRL_ADDRESS with operand_valid_in high.
  - Accepted only in IDLE or FAULT. An accepted write latches target/read_req, clears drop and fault, and moves to SWITCH_OUT on the next cycle.
  - A write in any other state is ignored and sets drop.
- States:
  - IDLE: buffer_clock_sel_out = read_req | (target == 0).
  - SWITCH_OUT: buffer_clock_sel_out = 1. Count SETTLE_CYCLES, then go to APPLY.
  - APPLY: pllpowerdown_n_out <= target for one cycle. Go to WAIT_LOCK if target != 0, else to SETTLE_BACK.
  - WAIT_LOCK: counter increments each cycle.
    - If (pll_locked_in & target) == target, go to SETTLE_BACK with counter cleared.
    - Else, when counter == LOCK_TIMEOUT-1, set fault and go to FAULT.
    - If both are true in the same cycle, lock wins.
  - SETTLE_BACK: count SETTLE_CYCLES, then set buffer_clock_sel_out = read_req | (target == 0) and go to IDLE.
  - FAULT: buffer_clock_sel_out = 1; pllpowerdown_n_out holds target. Exits only on an accepted write.
- Counter: width $clog2(LOCK_TIMEOUT+1); cleared on every state entry.
- Reset mid-sequence: at the next edge, all outputs and the state return to their reset values. No partial select change is held over.
- Status byte: {busy[7], fault[6], drop[5], sel[4], lock[3:0]}, with lock bits above NUM_PLLS-1 reading 0.
- Readback:
  - response_out is registered with 1-cycle latency.
  - opcode CTRL_ADDRESS returns the control register; STATUS_ADDRESS returns the status byte; any other opcode returns 0.
  - Reads have no side effects.
- Invariant: buffer_clock_sel_out is 1 in every cycle in which any PLL is powered down or unlocked outside IDLE.

Optional Feature:
- Macro: PLL_LOCK_MONITOR_EN.
- Defined: in IDLE, if (pll_locked_in & target) != target for 2 consecutive cycles, buffer_clock_sel_out goes to 1 on the next cycle, fault is set, and the FSM enters FAULT.
- Undefined: lock is sampled only in WAIT_LOCK, and loss of lock in IDLE is ignored.

Test Plan:
1. Reset, then pll_locked_in = 2'b11 after 50 cycles -> busy_out = 1 and sel = 1 until lock; SETTLE_BACK runs 16 cycles; then sel = 0, busy_out = 0, status = 8'h03.
2. In IDLE, write 8'h80 to 'hE0 -> sel = 1 within 1 cycle; 16 cycles later pllpowerdown_n_out = 2'b00; FSM skips WAIT_LOCK; IDLE with sel = 1 after SETTLE_BACK.
3. Write 8'h03 while locks are held low -> fault after exactly 1024 WAIT_LOCK cycles; status = 8'h50; a new write 8'h03 with locks high clears fault and returns to IDLE with sel = 0.
4. Write 8'h01 during SWITCH_OUT -> write ignored, drop = 1, target unchanged; the next accepted write clears drop.
5. Assert reset_in in the 5th cycle of WAIT_LOCK -> next edge gives pllpowerdown_n_out = 2'b11, sel = 1, response_out = 0, counter = 0.
6. PLL_LOCK_MONITOR_EN defined, IDLE with sel = 0: drop pll_locked_in[1] for 2 cycles -> sel = 1 and fault = 1 on the third cycle; a 1-cycle glitch leaves the FSM in IDLE.

Source files
------------

// File: rtl/pll_sequencer_csr.sv
// PLL power / image-buffer clock-select sequencer with control and status registers.
// Optional IDLE lock monitor: define PLL_LOCK_MONITOR_EN.
module pll_sequencer_csr #(
    parameter int          NUM_PLLS       = 2,
    parameter logic [7:0]  CTRL_ADDRESS   = 8'hE0,
    parameter logic [7:0]  STATUS_ADDRESS = 8'hE1,
    parameter int          SETTLE_CYCLES  = 16,
    parameter int          LOCK_TIMEOUT   = 1024
) (
    input  logic                clock_in,
    input  logic                reset_in,
    input  logic [7:0]          opcode_in,
    input  logic [7:0]          operand_in,
    input  logic                operand_valid_in,
    output logic [7:0]          response_out,
    input  logic [NUM_PLLS-1:0] pll_locked_in,
    output logic [NUM_PLLS-1:0] pllpowerdown_n_out,
    output logic                buffer_clock_sel_out,
    output logic                busy_out
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWITCH_OUT,
        S_APPLY,
        S_WAIT_LOCK,
        S_SETTLE_BACK,
        S_FAULT
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      counter_q, counter_d;
    logic [NUM_PLLS-1:0]   target_q, target_d;
    logic                  read_req_q, read_req_d;
    logic                  drop_q, drop_d;
    logic                  fault_q, fault_d;
    logic [NUM_PLLS-1:0]   pd_n_q, pd_n_d;
    logic                  sel_q, sel_d;
    logic [7:0]            resp_q, resp_d;

    logic                  wr;
    logic                  accept;
    logic                  lock_ok;
    logic                  busy;
    logic [3:0]            lock_field;
    logic [7:0]            ctrl_byte;
    logic [7:0]            status_byte;
    logic                  unused_operand_bits;

    assign wr      = (opcode_in == CTRL_ADDRESS) && operand_valid_in;
    assign accept  = wr && ((state_q == S_IDLE) || (state_q == S_FAULT));
    assign lock_ok = ((pll_locked_in & target_q) == target_q);
    assign busy    = (state_q != S_IDLE) && (state_q != S_FAULT);
    assign unused_operand_bits = ^operand_in[6:NUM_PLLS];

    // Status lock field is always 4 bits wide; PLLs that do not exist read 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lock
        if (gi < NUM_PLLS) begin : g_used
            assign lock_field[gi] = pll_locked_in[gi];
        end else begin : g_unused
            assign lock_field[gi] = 1'b0;
        end
    end

    always_comb begin
        ctrl_byte                 = '0;
        ctrl_byte[7]              = read_req_q;
        ctrl_byte[NUM_PLLS-1:0]   = target_q;
    end

    assign status_byte = {busy, fault_q, drop_q, sel_q, lock_field};

`ifdef PLL_LOCK_MONITOR_EN
    logic mon_q, mon_d;

    assign mon_d = (state_q == S_IDLE) && !lock_ok;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            mon_q <= 1'b0;
        end else begin
            mon_q <= mon_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        target_d   = target_q;
        read_req_d = read_req_q;
        drop_d     = drop_q;
        fault_d    = fault_q;
        pd_n_d     = pd_n_q;
        sel_d      = sel_q;

        case (state_q)
            S_IDLE: begin
                sel_d = read_req_q | (target_q == '0);
`ifdef PLL_LOCK_MONITOR_EN
                if (mon_q && !lock_ok) begin
                    state_d   = S_FAULT;
                    fault_d   = 1'b1;
                    sel_d     = 1'b1;
                    counter_d = '0;
                end
`endif
            end
            S_SWITCH_OUT: begin
                sel_d = 1'b1;
                if (counter_q == SETTLE_LAST) begin
                    state_d   = S_APPLY;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            S_APPLY: begin
                pd_n_d    = target_q;
                counter_d = '0;
                state_d   = (target_q != '0) ? S_WAIT_LOCK : S_SETTLE_BACK;
            end
            S_WAIT_LOCK: begin
                // Lock is tested first so it wins over a coincident timeout.
                if (lock_ok) begin
                    state_d   = S_SETTLE_BACK;
                    counter_d = '0;
                end else if (counter_q == TIMEOUT_LAST) begin
                    state_d   = S_FAULT;
                    fault_d   = 1'b1;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            S_SETTLE_BACK: begin
                if (counter_q == SETTLE_LAST) begin
                    sel_d     = read_req_q | (target_q == '0);
                    state_d   = S_IDLE;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                sel_d  = 1'b1;
                pd_n_d = target_q;
            end
            default: begin
                state_d   = S_FAULT;
                sel_d     = 1'b1;
                counter_d = '0;
            end
        endcase

        // The buffer clock moves to SPI on the same edge a command is accepted.
        if (accept) begin
            target_d   = operand_in[NUM_PLLS-1:0];
            read_req_d = operand_in[7];
            drop_d     = 1'b0;
            fault_d    = 1'b0;
            sel_d      = 1'b1;
            state_d    = S_SWITCH_OUT;
            counter_d  = '0;
        end else if (wr) begin
            drop_d = 1'b1;
        end
    end

    always_comb begin
        resp_d = 8'h00;
        if (opcode_in == CTRL_ADDRESS) begin
            resp_d = ctrl_byte;
        end else if (opcode_in == STATUS_ADDRESS) begin
            resp_d = status_byte;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= S_WAIT_LOCK;
            counter_q  <= '0;
            target_q   <= '1;
            read_req_q <= 1'b0;
            drop_q     <= 1'b0;
            fault_q    <= 1'b0;
            pd_n_q     <= '1;
            sel_q      <= 1'b1;
            resp_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            target_q   <= target_d;
            read_req_q <= read_req_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
            pd_n_q     <= pd_n_d;
            sel_q      <= sel_d;
            resp_q     <= resp_d;
        end
    end

    assign response_out         = resp_q;
    assign pllpowerdown_n_out   = pd_n_q;
    assign buffer_clock_sel_out = sel_q;
    assign busy_out             = busy;

endmodule

// File: tb/tb_pll_sequencer_csr.sv
// Self-checking bench for pll_sequencer_csr: reset, directed corner sequences,
// a write/readback vector table and randomized transactions against a timeline model.
module tb_pll_sequencer_csr;

    localparam int N  = 2;
    localparam int S  = 16;
    localparam int LT = 1024;

    logic       clk = 1'b0;
    logic       reset_in;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       valid;
    logic [7:0] resp;
    logic [N-1:0] locks;
    logic [N-1:0] pd_n;
    logic       sel;
    logic       busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pll_sequencer_csr #(
        .NUM_PLLS       (N),
        .CTRL_ADDRESS   (8'hE0),
        .STATUS_ADDRESS (8'hE1),
        .SETTLE_CYCLES  (S),
        .LOCK_TIMEOUT   (LT)
    ) dut (
        .clock_in             (clk),
        .reset_in             (reset_in),
        .opcode_in            (opcode),
        .operand_in           (operand),
        .operand_valid_in     (valid),
        .response_out         (resp),
        .pll_locked_in        (locks),
        .pllpowerdown_n_out   (pd_n),
        .buffer_clock_sel_out (sel),
        .busy_out             (busy)
    );

    typedef struct {
        logic [7:0] wdata;
        logic [7:0] exp_ctrl;
        logic       exp_sel;
        logic [1:0] exp_pd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        opcode  = 8'hE0;
        operand = v;
        valid   = 1'b1;
        tick();
        opcode  = 8'h00;
        valid   = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [7:0] v);
        opcode = addr;
        tick();
        v      = resp;
        opcode = 8'h00;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[5];
        logic [7:0] rd;
        int         n;
        int         bad;

        vecs[0] = '{8'h03, 8'h03, 1'b0, 2'b11};
        vecs[1] = '{8'h81, 8'h81, 1'b1, 2'b01};
        vecs[2] = '{8'h7E, 8'h02, 1'b0, 2'b10};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 2'b00};
        vecs[4] = '{8'hFF, 8'h83, 1'b1, 2'b11};

        // Reset and power-up sequencing
        reset_in = 1'b1; opcode = 8'h00; operand = 8'h00; valid = 1'b0; locks = 2'b00;
        tick(); tick();
        check("reset pd_n", pd_n, 2'b11);
        check("reset sel", sel, 1'b1);
        check("reset response", resp, 8'h00);
        check("reset busy", busy, 1'b1);
        reset_in = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (!busy || !sel) bad++;
        end
        check("t1 busy/sel before lock", bad, 0);
        locks = 2'b11;
        wait_idle(100, n);
        check("t1 lock+settle cycles", n, S + 1);
        check("t1 sel idle", sel, 1'b0);
        read_reg(8'hE1, rd);
        check("t1 status", rd, 8'h03);

        // Read request with all PLLs off: WAIT_LOCK skipped
        write_ctrl(8'h80);
        check("t2 sel after write", sel, 1'b1);
        repeat (S) tick();
        check("t2 power held during settle", pd_n, 2'b11);
        tick();
        check("t2 power down", pd_n, 2'b00);
        wait_idle(100, n);
        check("t2 settle back cycles", n, S);
        check("t2 sel idle", sel, 1'b1);
        read_reg(8'hE0, rd);
        check("t2 ctrl readback", rd, 8'h80);

        // Lock timeout -> fault, then recovery
        locks = 2'b00;
        write_ctrl(8'h03);
        wait_idle(3000, n);
        check("t3 cycles to fault", n, S + 1 + LT);
        check("t3 fault sel", sel, 1'b1);
        read_reg(8'hE1, rd);
        check("t3 fault status", rd, 8'h50);
        locks = 2'b11;
        write_ctrl(8'h03);
        wait_idle(200, n);
        check("t3 recovery cycles", n, 2 * S + 2);
        check("t3 recovery sel", sel, 1'b0);
        read_reg(8'hE1, rd);
        check("t3 recovery status", rd, 8'h03);

        // Write during SWITCH_OUT is dropped
        write_ctrl(8'h03);
        tick(); tick();
        write_ctrl(8'h01);
        wait_idle(200, n);
        read_reg(8'hE0, rd);
        check("t4 target unchanged", rd, 8'h03);
        read_reg(8'hE1, rd);
        check("t4 drop status", rd, 8'h23);
        write_ctrl(8'h03);
        wait_idle(200, n);
        read_reg(8'hE1, rd);
        check("t4 drop cleared", rd, 8'h03);

        // Reset in the 5th WAIT_LOCK cycle
        locks = 2'b00;
        write_ctrl(8'h01);
        repeat (S + 1 + 4) tick();
        check("t5 pre-reset pd_n", pd_n, 2'b01);
        reset_in = 1'b1;
        opcode   = 8'hE1;
        tick();
        reset_in = 1'b0;
        opcode   = 8'h00;
        check("t5 reset pd_n", pd_n, 2'b11);
        check("t5 reset sel", sel, 1'b1);
        check("t5 reset response", resp, 8'h00);
        check("t5 reset busy", busy, 1'b1);
        wait_idle(3000, n);
        check("t5 counter restarted", n, LT);
        read_reg(8'hE0, rd);
        check("t5 ctrl after reset", rd, 8'h03);
        locks = 2'b11;
        write_ctrl(8'h03);
        wait_idle(200, n);
        check("t5 recovered sel", sel, 1'b0);

        // Loss of lock in IDLE
`ifdef PLL_LOCK_MONITOR_EN
        locks = 2'b01;
        tick();
        locks = 2'b11;
        repeat (3) tick();
        check("t6 glitch busy", busy, 1'b0);
        check("t6 glitch sel", sel, 1'b0);
        read_reg(8'hE1, rd);
        check("t6 glitch status", rd, 8'h03);
        locks = 2'b01;
        tick();
        check("t6 one cycle low sel", sel, 1'b0);
        tick();
        check("t6 two cycles low sel", sel, 1'b1);
        read_reg(8'hE1, rd);
        check("t6 monitor fault status", rd, 8'h51);
        locks = 2'b11;
        write_ctrl(8'h03);
        wait_idle(200, n);
        check("t6 recovered sel", sel, 1'b0);
`else
        locks = 2'b01;
        repeat (5) tick();
        check("t6 lock loss ignored sel", sel, 1'b0);
        check("t6 lock loss ignored busy", busy, 1'b0);
        read_reg(8'hE1, rd);
        check("t6 lock loss status", rd, 8'h01);
        locks = 2'b11;
        tick();
`endif

        // Write / readback vector table
        read_reg(8'h55, rd);
        check("other opcode reads 0", rd, 8'h00);
        for (int i = 0; i < 5; i++) begin
            write_ctrl(vecs[i].wdata);
            wait_idle(200, n);
            check($sformatf("vec%0d sel", i), sel, vecs[i].exp_sel);
            check($sformatf("vec%0d pd_n", i), pd_n, vecs[i].exp_pd);
            read_reg(8'hE0, rd);
            check($sformatf("vec%0d ctrl", i), rd, vecs[i].exp_ctrl);
        end

        // Randomized transactions against a timeline model
        for (int i = 0; i < 16; i++) begin
            logic [1:0] t;
            logic       rr;
            logic [7:0] res;
            logic [7:0] injv;
            logic       inj;
            logic       never;
            logic       faulted;
            logic       exp_sel;
            logic [1:0] exp_locks;
            int         m;
            int         w;
            int         exp_n;
            int         cnt;
            int         viol;

            t     = 2'($urandom_range(0, 3));
            rr    = 1'($urandom_range(0, 1));
            res   = 8'($urandom);
            injv  = 8'($urandom);
            inj   = 1'($urandom_range(0, 1));
            never = (i == 4) || (i == 11);
            m     = int'($urandom_range(0, 30));

            if (t == 2'b00) w = 0;
            else if (never) w = LT + 1;
            else w = ((m - (S + 1)) > 0 ? (m - (S + 1)) : 0) + 1;
            faulted   = (t != 2'b00) && (w > LT);
            exp_n     = faulted ? (S + 1 + LT) : (2 * S + 1 + w);
            exp_sel   = faulted ? 1'b1 : (rr | (t == 2'b00));
            exp_locks = never ? 2'b00 : 2'b11;

            locks = 2'b00;
            write_ctrl({rr, res[6:2], t});
            cnt  = 0;
            viol = 0;
            while (busy && cnt < 3000) begin
                if (!never && cnt == m) locks = 2'b11;
                if (inj && cnt == 2) begin
                    opcode = 8'hE0; operand = injv; valid = 1'b1;
                end
                if (cnt == 3) begin
                    opcode = 8'h00; valid = 1'b0;
                end
                tick();
                cnt++;
                if (busy && (pd_n != 2'b11 || locks != 2'b11) && !sel) viol++;
            end
            check($sformatf("rnd%0d busy cycles", i), cnt, exp_n);
            check($sformatf("rnd%0d sel invariant", i), viol, 0);
            check($sformatf("rnd%0d sel", i), sel, exp_sel);
            check($sformatf("rnd%0d pd_n", i), pd_n, t);
            read_reg(8'hE0, rd);
            check($sformatf("rnd%0d ctrl", i), rd, {rr, 5'b00000, t});
            read_reg(8'hE1, rd);
            check($sformatf("rnd%0d status", i), rd,
                  {1'b0, faulted, inj, exp_sel, 2'b00, exp_locks});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
